wb_mstr_mux: RTL
================

WB_MSTR_MUX -- requirements
Module: wb_mstr_mux

Interface
REQ-001 Parameter TIMEOUT_CYC, default 255, range 2..255: slave stall cycles before the block forces a bus error.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 m_cyc_i  input  3  master cycle request; bit n belongs to master n.
REQ-005 m_stb_i  input  3  master strobe per master.
REQ-006 m_we_i  input  3  master write enable per master.
REQ-007 m_adr_i  input  96  master address; master n at bits [32n+31:32n].
REQ-008 m_wdat_i  input  96  master write data; same packing as m_adr_i.
REQ-009 m_sel_i  input  12  master byte selects; master n at bits [4n+3:4n].
REQ-010 m_rdat_o  output  32  read data, broadcast to all masters.
REQ-011 m_ack_o  output  3  acknowledge per master.
REQ-012 m_err_o  output  3  error per master.
REQ-013 arb_req_o  output  3  request vector to the round-robin arbiter.
REQ-014 arb_gnt_i  input  2  grant index from the arbiter (0..2).
REQ-015 s_cyc_o, s_stb_o, s_we_o  output  1 each  slave cycle, strobe, write.
REQ-016 s_adr_o, s_wdat_o  output  32 each  slave address, write data.
REQ-017 s_sel_o  output  4  slave byte selects.
REQ-018 s_rdat_i  input  32  slave read data.
REQ-019 s_ack_i, s_err_i  input  1 each  slave acknowledge, error.
REQ-020 to_pulse_o  output  1  one-cycle pulse on a forced timeout.

Function
REQ-021 arb_req_o SHALL equal m_cyc_i combinationally in all states.
REQ-022 Two-state FSM, IDLE and BUSY, plus 2-bit owner register own_q.
REQ-023 IDLE: s_cyc_o = 0, s_stb_o = 0, m_ack_o = 0, m_err_o = 0.
REQ-024 IDLE -> BUSY when arb_gnt_i < 3 and m_cyc_i[arb_gnt_i] = 1; own_q <= arb_gnt_i at the same edge.
REQ-025 IDLE with arb_gnt_i = 3, or with the granted master's cyc low, SHALL remain IDLE.
REQ-026 BUSY routing:
  - s_cyc_o = m_cyc_i[own_q]; s_stb_o = m_stb_i[own_q], gated by REQ-033.
  - s_we_o, s_adr_o, s_wdat_o and s_sel_o come from master own_q.
REQ-027 BUSY: m_ack_o[own_q] = s_ack_i and m_err_o[own_q] = s_err_i; all other ack/err bits stay 0.
REQ-028 m_rdat_o SHALL equal s_rdat_i at all times.
REQ-029 BUSY -> IDLE when m_cyc_i[own_q] = 0; s_cyc_o is 0 in that cycle.
REQ-030 Ownership hand-over SHALL include at least one IDLE cycle; there are no back-to-back owners.
REQ-031 Changes on arb_gnt_i and m_cyc_i of non-owners during BUSY SHALL be ignored.
REQ-032 Multiple strobes inside one cycle (burst) SHALL pass through without leaving BUSY.

Reset
REQ-033 Timeout gating: s_stb_o SHALL be 0 in the cycle in which to_pulse_o = 1.
REQ-034 rst = 1 at an edge: FSM <= IDLE, own_q <= 0, timeout counter <= 0.
REQ-035 All outputs except arb_req_o and m_rdat_o SHALL be 0 from that edge on until the first post-reset grant.
REQ-036 Reset during BUSY SHALL abort the transfer; a late s_ack_i is not forwarded.

Configuration
REQ-037 Macro WB_MUX_TIMEOUT_EN.
  - Defined: an 8-bit counter increments each cycle with s_stb_o = 1, s_ack_i = 0 and s_err_i = 0, and clears otherwise.
  - When the counter reaches TIMEOUT_CYC, the next cycle gives m_err_o[own_q] = 1 and to_pulse_o = 1 for one cycle, and the counter clears.
  - Not defined: no counter; to_pulse_o is tied 0; m_err_o reflects only s_err_i.

Verification
REQ-038 Single read: m_cyc/stb[1] = 1, arb_gnt_i = 1, slave acks at cycle 3 with 0xA5A5_0001.
  - Required: m_ack_o = 3'b010 for one cycle, m_rdat_o = 0xA5A5_0001, and IDLE one cycle after cyc drops.
REQ-039 Contention: masters 0 and 2 hold cyc; arb_gnt_i = 0 then 2.
  - Required: master 0 served first; s_cyc_o is 0 for at least one cycle; then master 2 owns; m_ack_o[2] is never set during master 0's cycle.
REQ-040 Grant swap mid-cycle: owner 0 in BUSY, arb_gnt_i switches to 1 -> own_q stays 0 and routing is unchanged until m_cyc_i[0] drops.
REQ-041 Timeout (macro defined, TIMEOUT_CYC = 4): stb held, no ack -> m_err_o[own_q] = 1 and to_pulse_o = 1 in the 5th stall cycle, with s_stb_o = 0 that cycle.
REQ-042 Reset mid-write: rst = 1 while BUSY with own_q = 2 -> s_cyc_o = 0 the next cycle; an s_ack_i one cycle later gives m_ack_o = 0.
REQ-043 Invalid grant: arb_gnt_i = 3 with m_cyc_i = 3'b111 -> FSM stays IDLE and s_cyc_o = 0.

Source files
------------

// File: rtl/wb_mstr_mux.sv
// Three-master Wishbone multiplexer onto a single slave port, driven by an external grant index.
// Defining WB_MUX_TIMEOUT_EN adds a stall watchdog that forces a bus error after TIMEOUT_CYC cycles.
module wb_mstr_mux #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  m_cyc_i,
  input  logic [2:0]  m_stb_i,
  input  logic [2:0]  m_we_i,
  input  logic [95:0] m_adr_i,
  input  logic [95:0] m_wdat_i,
  input  logic [11:0] m_sel_i,
  output logic [31:0] m_rdat_o,
  output logic [2:0]  m_ack_o,
  output logic [2:0]  m_err_o,
  output logic [2:0]  arb_req_o,
  input  logic [1:0]  arb_gnt_i,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_wdat_o,
  output logic [3:0]  s_sel_o,
  input  logic [31:0] s_rdat_i,
  input  logic        s_ack_i,
  input  logic        s_err_i,
  output logic        to_pulse_o
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e      state_q, state_d;
  logic [1:0]  own_q, own_d;
  logic        busy;
  logic        to_hit;

  logic        own_cyc, own_stb, own_we;
  logic [31:0] own_adr, own_wdat;
  logic [3:0]  own_sel;

  assign busy      = (state_q == StBusy);
  assign arb_req_o = m_cyc_i;
  assign m_rdat_o  = s_rdat_i;

  always_comb begin
    own_cyc  = 1'b0;
    own_stb  = 1'b0;
    own_we   = 1'b0;
    own_adr  = '0;
    own_wdat = '0;
    own_sel  = '0;
    case (own_q)
      2'd0: begin
        own_cyc  = m_cyc_i[0];
        own_stb  = m_stb_i[0];
        own_we   = m_we_i[0];
        own_adr  = m_adr_i[31:0];
        own_wdat = m_wdat_i[31:0];
        own_sel  = m_sel_i[3:0];
      end
      2'd1: begin
        own_cyc  = m_cyc_i[1];
        own_stb  = m_stb_i[1];
        own_we   = m_we_i[1];
        own_adr  = m_adr_i[63:32];
        own_wdat = m_wdat_i[63:32];
        own_sel  = m_sel_i[7:4];
      end
      2'd2: begin
        own_cyc  = m_cyc_i[2];
        own_stb  = m_stb_i[2];
        own_we   = m_we_i[2];
        own_adr  = m_adr_i[95:64];
        own_wdat = m_wdat_i[95:64];
        own_sel  = m_sel_i[11:8];
      end
      default: ;
    endcase
  end

`ifdef WB_MUX_TIMEOUT_EN
  logic [7:0] to_cnt_q, to_cnt_d;

  // The forced-error cycle drops s_stb_o, which also clears the counter.
  assign to_hit = busy && (to_cnt_q == 8'(TIMEOUT_CYC));

  always_comb begin
    to_cnt_d = '0;
    if (s_stb_o && !s_ack_i && !s_err_i) begin
      to_cnt_d = to_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`else
  assign to_hit = 1'b0;
`endif

  assign to_pulse_o = to_hit;

  always_comb begin
    state_d = state_q;
    own_d   = own_q;
    case (state_q)
      StIdle: begin
        if (arb_gnt_i != 2'd3 && m_cyc_i[arb_gnt_i]) begin
          state_d = StBusy;
          own_d   = arb_gnt_i;
        end
      end
      StBusy: begin
        // Grant and other masters are ignored until the owner releases cyc.
        if (!own_cyc) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_adr_o  = '0;
    s_wdat_o = '0;
    s_sel_o  = '0;
    m_ack_o  = '0;
    m_err_o  = '0;
    if (busy) begin
      s_cyc_o  = own_cyc;
      s_stb_o  = own_stb & ~to_hit;
      s_we_o   = own_we;
      s_adr_o  = own_adr;
      s_wdat_o = own_wdat;
      s_sel_o  = own_sel;
      m_ack_o  = {2'b00, s_ack_i} << own_q;
      m_err_o  = {2'b00, (s_err_i | to_hit)} << own_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      own_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
    end
  end

endmodule
